lsu_mem_master: RTL and testbench

//  Load/store initiator that drives the data-memory read (AR/R) and write (AW/W/B) channels.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_mem_master_if.sv | 52 +++++
 rtl/lsu_timeout_cnt.sv | 39 +++
 rtl/lsu_mem_master.sv | 176 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store memory master:
//     XLEN            data/address width of the memory interface
//     lsu_state_t     FSM state encoding (IDLE, RD, WR, WB, RESP)
//     LEN_B/H/W       legal access sizes in bytes
//     len_legal()     true when a requested access size is 1, 2 or 4 bytes
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } lsu_state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  function automatic logic len_legal(input logic [2:0] len);
    return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_master_if
//   Data-memory bus between the LSU (master) and the data memory (slave).
//   Read address : arvalid, araddr, load_unsign (M->S), arready (S->M)
//   Read data    : rvalid, rdata, rresp (S->M, rresp 1 = OK), rready (M->S)
//   Write address: awvalid, awaddr (M->S), awready (S->M)
//   Write data   : wvalid, wdata (M->S), wready (S->M)
//   Size         : len (M->S), access bytes zero-extended, shared by R and W
//   Write resp   : bvalid, bresp (S->M), bready (M->S)
// ---------------------------------------------------------------------------
interface lsu_mem_master_if;
  import lsu_pkg::*;

  logic            arvalid;
  logic [XLEN-1:0] araddr;
  logic            load_unsign;
  logic            arready;

  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            rresp;
  logic            rready;

  logic            awvalid;
  logic [XLEN-1:0] awaddr;
  logic            awready;

  logic            wvalid;
  logic [XLEN-1:0] wdata;
  logic            wready;

  logic [XLEN-1:0] len;

  logic            bvalid;
  logic            bresp;
  logic            bready;

  modport master (
    output arvalid, araddr, load_unsign, rready,
    output awvalid, awaddr, wvalid, wdata, len, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, load_unsign, rready,
    input  awvalid, awaddr, wvalid, wdata, len, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/lsu_timeout_cnt.sv
// ---------------------------------------------------------------------------
// lsu_timeout_cnt
//   Wait-state watchdog for the LSU. The counter is held at zero while
//   i_en is low and counts cycles while i_en is high; o_expired flags the
//   cycle in which the count reaches TIMEOUT_CYCLES-1.
//   Instantiated by lsu_mem_master only when LSU_TIMEOUT_EN is defined.
//   Ports:
//     clk        in   clock
//     rst        in   asynchronous active-high reset
//     i_en       in   LSU is waiting in RD or WB
//     o_expired  out  wait limit reached this cycle
// ---------------------------------------------------------------------------
module lsu_timeout_cnt
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_expired
);

  logic [XLEN-1:0] r_cnt;

  // Clearing whenever not waiting makes every entry into RD/WB start at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == XLEN'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator for the data memory. Accepts one load or store at a
//   time from the execute stage, runs the AR/R or AW/W/B handshakes and
//   returns read data / write completion on the response port.
//   Optional feature macro: LSU_TIMEOUT_EN -- abort RD/WB waits after
//   TIMEOUT_CYCLES cycles with an error response (lsu_timeout_cnt).
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     req_valid/ready     request handshake
//     req_wen             1 = store, 0 = load
//     req_addr/wdata      byte address, right-aligned store data
//     req_len             access bytes (1, 2, 4; anything else -> error)
//     req_unsign          load zero-extend (1) / sign-extend (0)
//     resp_valid/ready    response handshake, response held until taken
//     resp_rdata/err      load data (0 for stores/errors), error flag
//     mem                 data-memory bus (master side)
// ---------------------------------------------------------------------------
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  input  logic [2:0]              req_len,
  input  logic                    req_unsign,

  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_rdata,
  output logic                    resp_err,

  lsu_mem_master_if.master        mem
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu_mem_master: TIMEOUT_CYCLES must be non-zero");
  end

  lsu_state_t      r_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_len;
  logic            r_unsign;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic            r_aw_done;
  logic            r_w_done;

  logic            w_req_hs;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_aw_ok;
  logic            w_w_ok;
  logic            w_timeout;
  logic            w_unused_bresp;

  // Stale R/B beats left over from an aborted transaction are drained in
  // IDLE; no new request is taken while one is still on the bus.
  assign req_ready = (r_state == S_IDLE) && !mem.rvalid && !mem.bvalid;
  assign w_req_hs  = req_valid && req_ready;

  assign mem.arvalid     = (r_state == S_RD);
  assign mem.rready      = (r_state == S_IDLE) || (r_state == S_RD);
  assign mem.araddr      = r_addr;
  assign mem.load_unsign = r_unsign;

  // Each write valid drops once its own handshake is recorded, so an
  // early AW or W acceptance is never repeated while the other waits.
  assign mem.awvalid = (r_state == S_WR) && !r_aw_done;
  assign mem.wvalid  = (r_state == S_WR) && !r_w_done;
  assign mem.awaddr  = r_addr;
  assign mem.wdata   = r_wdata;
  assign mem.bready  = (r_state == S_IDLE) || (r_state == S_WB);

  assign mem.len = {{(XLEN-3){1'b0}}, r_len};

  assign w_aw_hs = mem.awvalid && mem.awready;
  assign w_w_hs  = mem.wvalid && mem.wready;
  assign w_aw_ok = r_aw_done || w_aw_hs;
  assign w_w_ok  = r_w_done || w_w_hs;

  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_unused_bresp = mem.bresp;

`ifdef LSU_TIMEOUT_EN
  logic w_waiting;
  assign w_waiting = (r_state == S_RD) || (r_state == S_WB);

  lsu_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_waiting),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_len     <= '0;
      r_unsign  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_len     <= req_len;
            r_unsign  <= req_unsign;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (!len_legal(req_len)) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else if (req_wen) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (mem.rvalid) begin
            r_rdata <= mem.rresp ? mem.rdata : '0;
            r_err   <= !mem.rresp;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if (w_aw_ok && w_w_ok) r_state <= S_WB;
        end
        S_WB: begin
          if (mem.bvalid) begin
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_master
//   Bench for lsu_mem_master: a small memory responder drives the slave side
//   of the bus and counts channel activity; expected responses are queued
//   when each request is issued and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_len;
  logic        req_unsign;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_mem_master_if mem_if();

  lsu_mem_master #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .req_unsign (req_unsign),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem        (mem_if)
  );

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  exp_t        exp_q[$];

  // memory responder configuration (written by the test sequence)
  int unsigned rd_delay = 0;
  int unsigned aw_delay = 0;
  bit          rd_never = 0;
  logic [31:0] mem_rword = '0;
  logic        mem_rresp = 1'b1;

  // activity counters and captures (written only by the responder)
  int unsigned n_ar_hs = 0, n_aw_hs = 0, n_w_hs = 0, n_resp_hs = 0;
  int unsigned n_arv_cyc = 0, n_awv_cyc = 0, n_wv_cyc = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [31:0] cap_rlen = '0, cap_wlen = '0;
  logic        cap_unsign = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : mem_model
    logic ar_take, r_hs, aw_hs, w_hs, b_hs, awv_pre;
    int unsigned rd_cnt, aw_seen;
    bit rd_pend, aw_got, w_got;
    rd_cnt = 0; aw_seen = 0; rd_pend = 0; aw_got = 0; w_got = 0;
    mem_if.arready = 1'b1; mem_if.rvalid = 1'b0; mem_if.rdata = '0; mem_if.rresp = 1'b0;
    mem_if.awready = 1'b1; mem_if.wready = 1'b1; mem_if.bvalid = 1'b0; mem_if.bresp = 1'b0;
    forever begin
      @(posedge clk);
      // sample what the edge just accepted
      ar_take = mem_if.arvalid && mem_if.arready && !mem_if.rvalid && !rd_pend;
      r_hs    = mem_if.rvalid && mem_if.rready;
      aw_hs   = mem_if.awvalid && mem_if.awready;
      w_hs    = mem_if.wvalid && mem_if.wready;
      b_hs    = mem_if.bvalid && mem_if.bready;
      awv_pre = mem_if.awvalid;
      if (mem_if.arvalid) n_arv_cyc++;
      if (mem_if.awvalid) n_awv_cyc++;
      if (mem_if.wvalid)  n_wv_cyc++;
      if (resp_valid && resp_ready) n_resp_hs++;
      if (ar_take) begin
        n_ar_hs++; cap_araddr = mem_if.araddr; cap_rlen = mem_if.len; cap_unsign = mem_if.load_unsign;
      end
      if (aw_hs) begin n_aw_hs++; cap_awaddr = mem_if.awaddr; cap_wlen = mem_if.len; aw_got = 1; end
      if (w_hs)  begin n_w_hs++; cap_wdata = mem_if.wdata; w_got = 1; end
      #1;
      if (r_hs) mem_if.rvalid = 1'b0;
      if (ar_take && !rd_never) begin rd_pend = 1; rd_cnt = rd_delay; end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_if.rvalid = 1'b1; mem_if.rdata = mem_rword; mem_if.rresp = mem_rresp; rd_pend = 0;
        end else begin
          rd_cnt--;
        end
      end
      if (b_hs) mem_if.bvalid = 1'b0;
      if (aw_got && w_got) begin mem_if.bvalid = 1'b1; aw_got = 0; w_got = 0; end
      if (aw_hs) aw_seen = 0;
      else if (awv_pre) aw_seen++;
      mem_if.awready = (aw_seen >= aw_delay);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives one request and returns one cycle after its handshake edge.
  task automatic do_req(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] len, input bit uns, output bit ok);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_len = len; req_unsign = uns; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      step();
    end
    step();
    req_valid = 1'b0;
  endtask

  // cyc = cycles from the request handshake to the cycle resp_valid is seen
  task automatic wait_resp(output int unsigned cyc, output bit ok);
    cyc = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin ok = 1'b1; break; end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    nvec++; if ({mem_if.rready, mem_if.bready} !== 2'b11) begin nerr++; $display("FAIL rst_readies got=%b exp=11", {mem_if.rready, mem_if.bready}); end
    nvec++; if ({mem_if.arvalid, mem_if.awvalid, mem_if.wvalid, resp_valid} !== 4'b0000) begin nerr++; $display("FAIL rst_valids got=%b exp=0000", {mem_if.arvalid, mem_if.awvalid, mem_if.wvalid, resp_valid}); end
    nvec++; if ({mem_if.araddr, mem_if.len, mem_if.wdata} !== 96'h0) begin nerr++; $display("FAIL rst_busregs got=%h exp=0", {mem_if.araddr, mem_if.len, mem_if.wdata}); end
    rst = 1'b0;
    step();
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    nvec++; if ({resp_rdata, resp_err} !== 33'h0) begin nerr++; $display("FAIL rst_resp got=%h exp=0", {resp_rdata, resp_err}); end
  endtask

  task automatic test_load_word();
    bit ok, rok; int unsigned cyc, arv0, ar0; exp_t e;
    arv0 = n_arv_cyc; ar0 = n_ar_hs;
    mem_rword = 32'h8765_4321; mem_rresp = 1'b1;
    exp_q.push_back('{32'h8765_4321, 1'b0});
    do_req(1'b0, 32'h8000_0100, 32'h0, 3'd4, 1'b0, ok);
    wait_resp(cyc, rok);
    nvec++; if (!(ok && rok)) begin nerr++; $display("FAIL ldw_timeout got=%b%b exp=11", ok, rok); end
    nvec++; if (cyc !== 3) begin nerr++; $display("FAIL ldw_latency got=%0d exp=3", cyc); end
    e = exp_q.pop_front();
    nvec++; if (resp_rdata !== e.rdata) begin nerr++; $display("FAIL ldw_rdata got=%h exp=%h", resp_rdata, e.rdata); end
    nvec++; if (resp_err !== e.err) begin nerr++; $display("FAIL ldw_err got=%b exp=%b", resp_err, e.err); end
    step();
    nvec++; if (n_arv_cyc - arv0 !== 2) begin nerr++; $display("FAIL ldw_arvalid_cycles got=%0d exp=2", n_arv_cyc - arv0); end
    nvec++; if (n_ar_hs - ar0 !== 1) begin nerr++; $display("FAIL ldw_ar_hs got=%0d exp=1", n_ar_hs - ar0); end
    nvec++; if ({cap_araddr, cap_rlen} !== {32'h8000_0100, 32'd4}) begin nerr++; $display("FAIL ldw_addr_len got=%h exp=%h", {cap_araddr, cap_rlen}, {32'h8000_0100, 32'd4}); end
  endtask

  task automatic test_load_byte();
    bit ok, rok; int unsigned cyc; exp_t e;
    mem_rword = 32'hFFFF_FF80; mem_rresp = 1'b1;
    exp_q.push_back('{32'hFFFF_FF80, 1'b0});
    do_req(1'b0, 32'h8000_0203, 32'h0, 3'd1, 1'b0, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    nvec++; if (!(ok && rok)) begin nerr++; $display("FAIL ldb_timeout got=%b%b exp=11", ok, rok); end
    nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL ldb_resp got=%h/%b exp=%h/%b", resp_rdata, resp_err, e.rdata, e.err); end
    nvec++; if ({cap_unsign, cap_rlen} !== {1'b0, 32'd1}) begin nerr++; $display("FAIL ldb_bus_unsign_len got=%b/%0d exp=0/1", cap_unsign, cap_rlen); end
    step();
  endtask

  task automatic test_load_err();
    bit ok, rok; int unsigned cyc; exp_t e;
    mem_rword = 32'h5555_AAAA; mem_rresp = 1'b0;
    exp_q.push_back('{32'h0, 1'b1});
    do_req(1'b0, 32'h0000_0044, 32'h0, 3'd2, 1'b1, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL lderr_resp got=%h/%b exp=%h/%b", resp_rdata, resp_err, e.rdata, e.err); end
    nvec++; if ({cap_unsign, cap_rlen} !== {1'b1, 32'd2}) begin nerr++; $display("FAIL lderr_bus_unsign_len got=%b/%0d exp=1/2", cap_unsign, cap_rlen); end
    mem_rresp = 1'b1;
    step();
  endtask

  task automatic test_store();
    bit ok, rok; int unsigned cyc, aw0, w0, rs0, wv0, awv0; exp_t e;
    aw0 = n_aw_hs; w0 = n_w_hs; rs0 = n_resp_hs; wv0 = n_wv_cyc; awv0 = n_awv_cyc;
    aw_delay = 3;
    exp_q.push_back('{32'h0, 1'b0});
    do_req(1'b1, 32'h2000_0010, 32'h1234_ABCD, 3'd2, 1'b0, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    nvec++; if (cyc !== 6) begin nerr++; $display("FAIL st_slow_latency got=%0d exp=6", cyc); end
    nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL st_resp got=%h/%b exp=%h/%b", resp_rdata, resp_err, e.rdata, e.err); end
    step();
    step();
    nvec++; if ({n_aw_hs - aw0, n_w_hs - w0} !== {32'd1, 32'd1}) begin nerr++; $display("FAIL st_hs_pairs got=%0d/%0d exp=1/1", n_aw_hs - aw0, n_w_hs - w0); end
    nvec++; if ({n_awv_cyc - awv0, n_wv_cyc - wv0} !== {32'd4, 32'd1}) begin nerr++; $display("FAIL st_valid_cycles got=%0d/%0d exp=4/1", n_awv_cyc - awv0, n_wv_cyc - wv0); end
    nvec++; if ({cap_awaddr, cap_wdata, cap_wlen} !== {32'h2000_0010, 32'h1234_ABCD, 32'd2}) begin nerr++; $display("FAIL st_bus_fields got=%h exp=%h", {cap_awaddr, cap_wdata, cap_wlen}, {32'h2000_0010, 32'h1234_ABCD, 32'd2}); end
    nvec++; if (n_resp_hs - rs0 !== 1) begin nerr++; $display("FAIL st_resp_count got=%0d exp=1", n_resp_hs - rs0); end
    aw_delay = 0;
    exp_q.push_back('{32'h0, 1'b0});
    do_req(1'b1, 32'h2000_0020, 32'hDEAD_BEEF, 3'd4, 1'b0, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    nvec++; if (cyc !== 3) begin nerr++; $display("FAIL st_fast_latency got=%0d exp=3", cyc); end
    nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL st_fast_resp got=%h/%b exp=%h/%b", resp_rdata, resp_err, e.rdata, e.err); end
    step();
  endtask

  task automatic test_bad_len();
    logic [2:0] lens [3];
    bit ok, rok; int unsigned cyc, act0; exp_t e;
    lens = '{3'd3, 3'd0, 3'd7};
    foreach (lens[k]) begin
      act0 = n_arv_cyc + n_awv_cyc + n_wv_cyc;
      exp_q.push_back('{32'h0, 1'b1});
      do_req(k[0], 32'h0000_1000, 32'hFFFF_FFFF, lens[k], 1'b0, ok);
      wait_resp(cyc, rok);
      e = exp_q.pop_front();
      nvec++; if (cyc !== 1) begin nerr++; $display("FAIL badlen%0d_latency got=%0d exp=1", lens[k], cyc); end
      nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL badlen%0d_resp got=%h/%b exp=%h/%b", lens[k], resp_rdata, resp_err, e.rdata, e.err); end
      step();
      nvec++; if (n_arv_cyc + n_awv_cyc + n_wv_cyc - act0 !== 0) begin nerr++; $display("FAIL badlen%0d_bus got=%0d exp=0", lens[k], n_arv_cyc + n_awv_cyc + n_wv_cyc - act0); end
    end
  endtask

  task automatic test_resp_stall();
    bit ok, rok; int unsigned cyc, rs0; exp_t e;
    rs0 = n_resp_hs;
    resp_ready = 1'b0;
    mem_rword = 32'hCAFE_0001;
    exp_q.push_back('{32'hCAFE_0001, 1'b0});
    do_req(1'b0, 32'h0000_0200, 32'h0, 3'd4, 1'b1, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    req_valid = 1'b1; req_wen = 1'b1; req_len = 3'd4;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++; if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin nerr++; $display("FAIL stall_hold%0d got=%b%b%b/%h exp=10%b/%h", i, resp_valid, req_ready, resp_err, resp_rdata, e.err, e.rdata); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    nvec++; if ({resp_valid, req_ready} !== 2'b01) begin nerr++; $display("FAIL stall_release got=%b%b exp=01", resp_valid, req_ready); end
    nvec++; if (n_resp_hs - rs0 !== 1) begin nerr++; $display("FAIL stall_resp_count got=%0d exp=1", n_resp_hs - rs0); end
  endtask

  task automatic test_back_to_back();
    bit ok, rok; int unsigned cyc; exp_t e; bit wen; logic [31:0] d;
    for (int t = 0; t < 8; t++) begin
      wen = t[0] ^ t[2];
      d = $urandom;
      mem_rword = d;
      exp_q.push_back('{wen ? 32'h0 : d, 1'b0});
      do_req(wen, $urandom & 32'hFFFF_FFFC, d ^ 32'h5A5A_5A5A, 3'd4, 1'b0, ok);
      wait_resp(cyc, rok);
      e = exp_q.pop_front();
      nvec++; if ({resp_rdata, resp_err, cyc} !== {e.rdata, e.err, 32'd3}) begin nerr++; $display("FAIL b2b%0d got=%h/%b/%0d exp=%h/%b/3", t, resp_rdata, resp_err, cyc, e.rdata, e.err); end
      if (wen) begin
        nvec++; if (cap_wdata !== (d ^ 32'h5A5A_5A5A)) begin nerr++; $display("FAIL b2b%0d_wdata got=%h exp=%h", t, cap_wdata, d ^ 32'h5A5A_5A5A); end
      end
    end
    step();
  endtask

  task automatic test_rst_midflight();
    bit ok, seen; int unsigned rs0;
    rs0 = n_resp_hs;
    rd_delay = 4;
    mem_rword = 32'h1111_2222;
    do_req(1'b0, 32'h0000_0300, 32'h0, 3'd4, 1'b0, ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_if.rvalid) begin seen = 1'b1; break; end
      step();
    end
    nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL rstmid_stale_seen got=%b exp=1", seen); end
    nvec++; if ({req_ready, mem_if.rready, resp_valid} !== 3'b010) begin nerr++; $display("FAIL rstmid_drain got=%b%b%b exp=010", req_ready, mem_if.rready, resp_valid); end
    step();
    nvec++; if ({mem_if.rvalid, req_ready} !== 2'b01) begin nerr++; $display("FAIL rstmid_after got=%b%b exp=01", mem_if.rvalid, req_ready); end
    repeat (3) step();
    nvec++; if (n_resp_hs - rs0 !== 0) begin nerr++; $display("FAIL rstmid_no_resp got=%0d exp=0", n_resp_hs - rs0); end
    rd_delay = 0;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, rok; int unsigned cyc; exp_t e;
    rd_never = 1'b1;
    exp_q.push_back('{32'h0, 1'b1});
    do_req(1'b0, 32'h0000_0400, 32'h0, 3'd4, 1'b0, ok);
    wait_resp(cyc, rok);
    e = exp_q.pop_front();
    nvec++; if (cyc !== 9) begin nerr++; $display("FAIL tmo_latency got=%0d exp=9", cyc); end
    nvec++; if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin nerr++; $display("FAIL tmo_resp got=%h/%b exp=%h/%b", resp_rdata, resp_err, e.rdata, e.err); end
    nvec++; if ({mem_if.arvalid, mem_if.awvalid, mem_if.wvalid} !== 3'b000) begin nerr++; $display("FAIL tmo_bus_idle got=%b exp=000", {mem_if.arvalid, mem_if.awvalid, mem_if.wvalid}); end
    rd_never = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; req_unsign = 1'b0; resp_ready = 1'b1;
    test_reset();
    test_load_word();
    test_load_byte();
    test_load_err();
    test_store();
    test_bad_len();
    test_resp_stall();
    test_back_to_back();
    test_rst_midflight();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
